// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot bubble fill, MEM waits, jumps, load-use.
// Optional MEM-wait timeout enabled by defining PIPE_MEM_TIMEOUT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_REQ,
  input  logic        mem_ACK,
  input  logic        ie_RAM_EN,
  input  logic        ie_RAM_op,
  input  logic        ie_WB_EN,
  input  logic [3:0]  ie_WB_ADDR,
  input  logic [3:0]  id_SRCA_ADDR,
  input  logic        id_SRCA_USE,
  input  logic [3:0]  id_SRCB_ADDR,
  input  logic        id_SRCB_USE,
  input  logic        ie_JUMP_TAKEN,
  input  logic        stat_CLR,
  output logic        pc_PAUSE,
  output logic        if_PAUSE,
  output logic        if_FLUSH,
  output logic        ie_PAUSE,
  output logic        ie_FLUSH,
  output logic        em_PAUSE,
  output logic        em_FLUSH,
  output logic        mw_FLUSH,
  output logic [1:0]  ctrl_STATE,
  output logic [15:0] stall_CNT,
  output logic        err_TIMEOUT
);

  typedef enum logic [1:0] {
    StBoot    = 2'b00,
    StRun     = 2'b01,
    StMemWait = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_hit;

  logic pc_pause, if_pause, if_flush, ie_pause, ie_flush, em_pause, em_flush, mw_flush;
  logic run_pc_pause, run_if_pause, run_if_flush, run_ie_flush;
  logic load_use;

  assign load_use = ie_RAM_EN & ~ie_RAM_op & ie_WB_EN &
                    ((id_SRCA_USE & (id_SRCA_ADDR == ie_WB_ADDR)) |
                     (id_SRCB_USE & (id_SRCB_ADDR == ie_WB_ADDR)));

  // Rules R2-R4; the structural case only needs mem_REQ because callers have
  // already established that the access completes (or is abandoned) this cycle.
  always_comb begin
    run_pc_pause = 1'b0;
    run_if_pause = 1'b0;
    run_if_flush = 1'b0;
    run_ie_flush = 1'b0;
    if (ie_JUMP_TAKEN) begin
      run_if_flush = 1'b1;
      run_ie_flush = 1'b1;
    end else if (load_use) begin
      run_pc_pause = 1'b1;
      run_if_pause = 1'b1;
      run_ie_flush = 1'b1;
    end else if (mem_REQ) begin
      run_pc_pause = 1'b1;
      run_if_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_pause   = 1'b0;
    if_pause   = 1'b0;
    if_flush   = 1'b0;
    ie_pause   = 1'b0;
    ie_flush   = 1'b0;
    em_pause   = 1'b0;
    em_flush   = 1'b0;
    mw_flush   = 1'b0;
    case (state_q)
      StRun: begin
        if (mem_REQ && !mem_ACK) begin
          {pc_pause, if_pause, ie_pause, em_pause, mw_flush} = 5'b11111;
          state_d = StMemWait;
        end else begin
          pc_pause = run_pc_pause;
          if_pause = run_if_pause;
          if_flush = run_if_flush;
          ie_flush = run_ie_flush;
        end
      end
      StMemWait: begin
        if (!mem_ACK && !timeout_hit) begin
          {pc_pause, if_pause, ie_pause, em_pause, mw_flush} = 5'b11111;
        end else begin
          pc_pause = run_pc_pause;
          if_pause = run_if_pause;
          if_flush = run_if_flush;
          ie_flush = run_ie_flush;
          state_d  = StRun;
        end
      end
      default: begin
        // Covers BOOT and the unreachable 2'b11 encoding.
        pc_pause = 1'b1;
        {if_flush, ie_flush, em_flush, mw_flush} = 4'b1111;
        if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
          boot_cnt_d = 4'd0;
          state_d    = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
          state_d    = StBoot;
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_CLR) begin
      stall_cnt_d = 16'd0;
    end else if ((state_q == StRun || state_q == StMemWait) && pc_pause &&
                 stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef PIPE_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  // The TIMEOUT-th consecutive wait cycle abandons the access.
  assign timeout_hit = (state_q == StMemWait) && !mem_ACK && (wait_cnt_q == 8'(TIMEOUT - 1));
  assign wait_cnt_d  = (state_q == StMemWait) ? wait_cnt_q + 8'd1 : 8'd0;
  assign err_d       = err_q | timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_TIMEOUT = err_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign err_TIMEOUT    = 1'b0;
`endif

  // A flush on the same register overrides a hold.
  assign pc_PAUSE   = pc_pause;
  assign if_PAUSE   = if_pause & ~if_flush;
  assign if_FLUSH   = if_flush;
  assign ie_PAUSE   = ie_pause & ~ie_flush;
  assign ie_FLUSH   = ie_flush;
  assign em_PAUSE   = em_pause & ~em_flush;
  assign em_FLUSH   = em_flush;
  assign mw_FLUSH   = mw_flush;
  assign ctrl_STATE = state_q;
  assign stall_CNT  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; the timeout scenario runs only with PIPE_MEM_TIMEOUT_EN.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] O_BOOT = 8'b1010_1011;
  localparam logic [7:0] O_WAIT = 8'b1101_0101;
  localparam logic [7:0] O_JUMP = 8'b0010_1000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_STR  = 8'b1010_0000;
  localparam logic [7:0] O_NONE = 8'b0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_REQ, mem_ACK, ie_RAM_EN, ie_RAM_op, ie_WB_EN;
  logic [3:0] ie_WB_ADDR, id_SRCA_ADDR, id_SRCB_ADDR;
  logic id_SRCA_USE, id_SRCB_USE, ie_JUMP_TAKEN, stat_CLR;
  logic pc_PAUSE, if_PAUSE, if_FLUSH, ie_PAUSE, ie_FLUSH, em_PAUSE, em_FLUSH, mw_FLUSH;
  logic [1:0] ctrl_STATE;
  logic [15:0] stall_CNT;
  logic err_TIMEOUT;
  logic [7:0] outs;

  int errors = 0;
  int checks = 0;

  assign outs = {pc_PAUSE, if_PAUSE, if_FLUSH, ie_PAUSE, ie_FLUSH, em_PAUSE, em_FLUSH, mw_FLUSH};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BOOT_CYCLES(3), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .mem_REQ(mem_REQ), .mem_ACK(mem_ACK),
    .ie_RAM_EN(ie_RAM_EN), .ie_RAM_op(ie_RAM_op), .ie_WB_EN(ie_WB_EN),
    .ie_WB_ADDR(ie_WB_ADDR), .id_SRCA_ADDR(id_SRCA_ADDR), .id_SRCA_USE(id_SRCA_USE),
    .id_SRCB_ADDR(id_SRCB_ADDR), .id_SRCB_USE(id_SRCB_USE),
    .ie_JUMP_TAKEN(ie_JUMP_TAKEN), .stat_CLR(stat_CLR),
    .pc_PAUSE(pc_PAUSE), .if_PAUSE(if_PAUSE), .if_FLUSH(if_FLUSH),
    .ie_PAUSE(ie_PAUSE), .ie_FLUSH(ie_FLUSH), .em_PAUSE(em_PAUSE),
    .em_FLUSH(em_FLUSH), .mw_FLUSH(mw_FLUSH), .ctrl_STATE(ctrl_STATE),
    .stall_CNT(stall_CNT), .err_TIMEOUT(err_TIMEOUT)
  );

  task automatic idle_inputs();
    mem_REQ = 0; mem_ACK = 0; ie_RAM_EN = 0; ie_RAM_op = 0; ie_WB_EN = 0;
    ie_WB_ADDR = 0; id_SRCA_ADDR = 0; id_SRCA_USE = 0; id_SRCB_ADDR = 0;
    id_SRCB_USE = 0; ie_JUMP_TAKEN = 0; stat_CLR = 0;
  endtask

  task automatic set_load_use();
    ie_RAM_EN = 1; ie_RAM_op = 0; ie_WB_EN = 1; ie_WB_ADDR = 4'd8;
    id_SRCA_USE = 1; id_SRCA_ADDR = 4'd8;
  endtask

  task automatic clear_stats();
    @(negedge clk); idle_inputs(); stat_CLR = 1;
    @(negedge clk); stat_CLR = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (outs !== O_BOOT) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, O_BOOT); end
    checks++; if (ctrl_STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", ctrl_STATE); end
    checks++; if (stall_CNT !== 16'd0 || err_TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL reset_regs: stall=%0d err=%b want 0/0", stall_CNT, err_TIMEOUT); end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs !== O_BOOT || ctrl_STATE !== 2'b00) begin
        errors++; $display("FAIL boot_cycle%0d: outs=%b st=%b want %b/00", i, outs, ctrl_STATE, O_BOOT); end
      @(negedge clk);
    end
    #1;
    checks++; if (outs !== O_NONE || ctrl_STATE !== 2'b01) begin
      errors++; $display("FAIL boot_exit: outs=%b st=%b want %b/01", outs, ctrl_STATE, O_NONE); end
    checks++; if (stall_CNT !== 16'd0) begin errors++; $display("FAIL boot_nocount: got %0d want 0", stall_CNT); end
  endtask

  task automatic test_load_use();
    clear_stats();
    set_load_use(); #1;
    checks++; if (outs !== O_LU) begin errors++; $display("FAIL lu_srca: got %b want %b", outs, O_LU); end
    @(negedge clk); #1;
    checks++; if (stall_CNT !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", stall_CNT); end
    id_SRCA_USE = 0; #1;
    checks++; if (outs !== O_NONE) begin errors++; $display("FAIL lu_unused: got %b want %b", outs, O_NONE); end
    id_SRCB_USE = 1; id_SRCB_ADDR = 4'd8; #1;
    checks++; if (outs !== O_LU) begin errors++; $display("FAIL lu_srcb: got %b want %b", outs, O_LU); end
    ie_RAM_op = 1; #1;
    checks++; if (outs !== O_NONE) begin errors++; $display("FAIL lu_store: got %b want %b", outs, O_NONE); end
    ie_RAM_op = 0; id_SRCB_ADDR = 4'd9; #1;
    checks++; if (outs !== O_NONE) begin errors++; $display("FAIL lu_addr_miss: got %b want %b", outs, O_NONE); end
    idle_inputs();
  endtask

  task automatic test_structural();
    clear_stats(); #1;
    checks++; if (stall_CNT !== 16'd0) begin errors++; $display("FAIL stat_clr: got %0d want 0", stall_CNT); end
    mem_REQ = 1; mem_ACK = 1; #1;
    checks++; if (outs !== O_STR) begin errors++; $display("FAIL struct_outs: got %b want %b", outs, O_STR); end
    @(negedge clk); #1;
    checks++; if (stall_CNT !== 16'd1) begin errors++; $display("FAIL struct_count: got %0d want 1", stall_CNT); end
    ie_JUMP_TAKEN = 1; #1;
    checks++; if (outs !== O_JUMP) begin errors++; $display("FAIL struct_jump: got %b want %b", outs, O_JUMP); end
    @(negedge clk); #1;
    checks++; if (stall_CNT !== 16'd1) begin errors++; $display("FAIL jump_nocount: got %0d want 1", stall_CNT); end
    ie_JUMP_TAKEN = 0; stat_CLR = 1;
    @(negedge clk); #1;
    checks++; if (stall_CNT !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", stall_CNT); end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    clear_stats();
    mem_REQ = 1; mem_ACK = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (outs !== O_WAIT || ctrl_STATE !== (i == 0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL wait_cycle%0d: outs=%b st=%b want %b", i, outs, ctrl_STATE, O_WAIT); end
      @(negedge clk);
    end
    mem_ACK = 1; #1;
    checks++; if (outs !== O_STR || ctrl_STATE !== 2'b10) begin
      errors++; $display("FAIL wait_ack: outs=%b st=%b want %b/10", outs, ctrl_STATE, O_STR); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (ctrl_STATE !== 2'b01 || outs !== O_NONE) begin
      errors++; $display("FAIL wait_exit: outs=%b st=%b want %b/01", outs, ctrl_STATE, O_NONE); end
    checks++; if (stall_CNT !== 16'd5) begin errors++; $display("FAIL wait_count: got %0d want 5", stall_CNT); end
    // Jump held through the wait is resolved on the ack cycle.
    mem_REQ = 1; mem_ACK = 0;
    @(negedge clk); ie_JUMP_TAKEN = 1; #1;
    checks++; if (outs !== O_WAIT) begin errors++; $display("FAIL wait_jump_held: got %b want %b", outs, O_WAIT); end
    @(negedge clk); mem_ACK = 1; #1;
    checks++; if (outs !== O_JUMP) begin errors++; $display("FAIL wait_jump_exit: got %b want %b", outs, O_JUMP); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (ctrl_STATE !== 2'b01) begin errors++; $display("FAIL wait_jump_state: got %b want 01", ctrl_STATE); end
  endtask

  task automatic test_priority();
    @(negedge clk); set_load_use(); ie_JUMP_TAKEN = 1; #1;
    checks++; if (outs !== O_JUMP) begin errors++; $display("FAIL prio_jump_lu: got %b want %b", outs, O_JUMP); end
    ie_JUMP_TAKEN = 0; mem_REQ = 1; mem_ACK = 1; #1;
    checks++; if (outs !== O_LU) begin errors++; $display("FAIL prio_lu_struct: got %b want %b", outs, O_LU); end
    mem_ACK = 0; ie_JUMP_TAKEN = 1; #1;
    checks++; if (outs !== O_WAIT) begin errors++; $display("FAIL prio_wait_jump: got %b want %b", outs, O_WAIT); end
    idle_inputs(); #1;
    checks++; if (ctrl_STATE !== 2'b01) begin errors++; $display("FAIL prio_state: got %b want 01", ctrl_STATE); end
  endtask

`ifdef PIPE_MEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk); mem_REQ = 1; mem_ACK = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (outs !== O_WAIT) begin errors++; $display("FAIL to_wait%0d: got %b want %b", i, outs, O_WAIT); end
      @(negedge clk);
    end
    #1;
    checks++; if (outs !== O_STR || ctrl_STATE !== 2'b10 || err_TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL to_abandon: outs=%b st=%b err=%b want %b/10/0", outs, ctrl_STATE, err_TIMEOUT, O_STR); end
    @(negedge clk); mem_REQ = 0; #1;
    checks++; if (ctrl_STATE !== 2'b01 || err_TIMEOUT !== 1'b1) begin
      errors++; $display("FAIL to_flag: st=%b err=%b want 01/1", ctrl_STATE, err_TIMEOUT); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_TIMEOUT !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_TIMEOUT); end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_wait();
    @(negedge clk); mem_REQ = 1; mem_ACK = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ctrl_STATE !== 2'b10) begin errors++; $display("FAIL mid_pre: got %b want 10", ctrl_STATE); end
    rst = 0; #1;
    checks++; if (outs !== O_BOOT || ctrl_STATE !== 2'b00) begin
      errors++; $display("FAIL mid_reset: outs=%b st=%b want %b/00", outs, ctrl_STATE, O_BOOT); end
    checks++; if (err_TIMEOUT !== 1'b0 || stall_CNT !== 16'd0) begin
      errors++; $display("FAIL mid_regs: err=%b stall=%0d want 0/0", err_TIMEOUT, stall_CNT); end
    idle_inputs();
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ctrl_STATE !== 2'b01) begin errors++; $display("FAIL mid_reboot: got %b want 01", ctrl_STATE); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_structural();
    test_mem_wait();
    test_priority();
`ifdef PIPE_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives pause and bubble-insert controls for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Resolves three hazards: load-use data hazards, single-port RAM contention between IF and MEM, and taken-jump squashes.
- Also sequences a post-reset bubble fill and multi-cycle MEM accesses.

Parameters:
- BOOT_CYCLES, 3, cycles of forced bubble fill after reset release (1..15)
- TIMEOUT, 255, max MEM_WAIT cycles; used only with the optional feature (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_REQ  in  1  MEM-stage instruction accesses shared RAM this cycle
- mem_ACK  in  1  RAM access completes this cycle
- ie_RAM_EN  in  1  EXE-stage instruction accesses RAM
- ie_RAM_op  in  1  EXE-stage RAM direction, 0=read 1=write
- ie_WB_EN  in  1  EXE-stage instruction writes a register
- ie_WB_ADDR  in  4  EXE-stage dest: 0-7 general regs, 8=SP 9=IH 10=RA 11=T
- id_SRCA_ADDR  in  4  ID-stage first source address, same encoding
- id_SRCA_USE  in  1  first source is read
- id_SRCB_ADDR  in  4  ID-stage second source address
- id_SRCB_USE  in  1  second source is read
- ie_JUMP_TAKEN  in  1  EXE resolved a taken jump/branch
- stat_CLR  in  1  synchronous clear of stall_CNT
- pc_PAUSE  out  1  hold PC
- if_PAUSE  out  1  hold IF/ID
- if_FLUSH  out  1  IF/ID loads NOP
- ie_PAUSE  out  1  hold ID/EXE
- ie_FLUSH  out  1  ID/EXE loads bubble (all ops disabled)
- em_PAUSE  out  1  hold EXE/MEM
- em_FLUSH  out  1  EXE/MEM loads bubble
- mw_FLUSH  out  1  MEM/WB loads bubble
- ctrl_STATE  out  2  current state, for debug
- stall_CNT  out  16  saturating count of stall cycles
- err_TIMEOUT  out  1  sticky MEM timeout flag (0 when feature absent)

Behaviour:
- Pause/flush outputs are combinational from state and inputs; state, counters and flags are registered.
- Pause = 1'b1 (`PAUSE_ENABLE).
- If pause and flush are both asserted on a register, flush wins.

Reset (rst=0):
- state=BOOT, boot counter=0, stall_CNT=0, err_TIMEOUT=0.
- pc_PAUSE=1; all four FLUSH=1; other pauses=0; ctrl_STATE=2'b00.

States:
- BOOT (2'b00):
  - pc_PAUSE=1 and all FLUSH=1.
  - Counter increments each cycle; after BOOT_CYCLES cycles, go to RUN.
  - Inputs ignored; stall_CNT not counted.
- RUN (2'b01): rules below, evaluated in priority order.
  - R1, MEM wait: mem_REQ=1 and mem_ACK=0.
    - pc_PAUSE, if_PAUSE, ie_PAUSE, em_PAUSE = 1; mw_FLUSH=1.
    - Next state MEM_WAIT.
  - R2, jump: ie_JUMP_TAKEN=1.
    - if_FLUSH=1, ie_FLUSH=1; pc_PAUSE=0 so PC loads the target.
    - Applies even when a single-cycle RAM access also occurs.
  - R3, load-use: ie_RAM_EN=1, ie_RAM_op=0, ie_WB_EN=1, and (id_SRCA_USE with id_SRCA_ADDR==ie_WB_ADDR, or id_SRCB_USE with id_SRCB_ADDR==ie_WB_ADDR).
    - pc_PAUSE=1, if_PAUSE=1, ie_FLUSH=1.
  - R4, structural: mem_REQ=1 and mem_ACK=1.
    - pc_PAUSE=1, if_FLUSH=1 (the fetch slot is lost).
  - Otherwise all outputs are 0.
- MEM_WAIT (2'b10):
  - mem_ACK=0: same outputs as R1.
  - mem_ACK=1: evaluate RUN rules R2-R4 as if in RUN (this is a structural cycle); next state RUN.
  - The jump in EXE is held paused and is re-resolved on exit; no pending-jump flag.
- Encoding 2'b11 is unreachable; if decoded, treat as BOOT.

stall_CNT:
- +1 on each RUN/MEM_WAIT cycle with pc_PAUSE=1; saturates at 16'hFFFF.
- stat_CLR has priority over increment.

Optional Feature:
Macro PIPE_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
  - On reaching TIMEOUT with mem_ACK=0: set err_TIMEOUT (sticky until reset) and go to RUN.
  - That cycle's outputs are the mem_ACK=1 outputs, so the access is abandoned and the pipeline resumes.
- Undefined: no counter; MEM_WAIT persists until mem_ACK; err_TIMEOUT tied to 0.

Test Plan:
- Reset with BOOT_CYCLES=3, release rst: all FLUSH=1 and pc_PAUSE=1 for exactly 3 cycles, then ctrl_STATE=2'b01 and all outputs 0.
- RUN, ie_RAM_EN=1, ie_RAM_op=0, ie_WB_EN=1, ie_WB_ADDR=4'd8 (SP), id_SRCA_USE=1, id_SRCA_ADDR=4'd8 -> pc_PAUSE=if_PAUSE=ie_FLUSH=1 for 1 cycle. Same with id_SRCA_USE=0 -> no stall.
- RUN, mem_REQ=1, mem_ACK=1 -> pc_PAUSE=1, if_FLUSH=1, stall_CNT 0->1. Add ie_JUMP_TAKEN=1 -> pc_PAUSE=0, if_FLUSH=ie_FLUSH=1.
- mem_REQ=1 held, mem_ACK low 4 cycles then high -> 4 cycles of pc/if/ie/em PAUSE with mw_FLUSH; ack cycle gives pc_PAUSE=1, if_FLUSH=1; state returns to 2'b01.
- Load-use and jump asserted together -> jump outputs only (if_FLUSH=ie_FLUSH=1, pc_PAUSE=0).
- With PIPE_MEM_TIMEOUT_EN and TIMEOUT=5, mem_ACK never asserted -> err_TIMEOUT=1 after 5 wait cycles, state RUN. Assert rst mid-MEM_WAIT -> immediate BOOT outputs and err_TIMEOUT=0.
